data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/dm_pkg.sv | 21 ++
 rtl/load_ext.sv | 26 ++
 rtl/data_memory.sv | 104 ++++++++++
 tb/tb_data_memory.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared encodings and defaults for the data memory and its load extender.
package dm_pkg;

  localparam int DM_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_SW   = 2'b00,
    ST_SH   = 2'b01,
    ST_SB   = 2'b10,
    ST_RSVD = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

endpackage

// File: rtl/load_ext.sv
// Combinational lane select plus zero/sign extension of a loaded word.
module load_ext
  import dm_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_load_type,
  output logic [31:0] o_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    w_byte = i_word[8*i_lane +: 8];
    case (load_type_e'(i_load_type))
      LT_LH:   o_data = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_data = {16'h0000, w_half};
      LT_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_data = {24'h000000, w_byte};
      default: o_data = i_word;  // lw and reserved encodings
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory with byte/half stores, extended loads,
// alignment/range exception flag and registered outputs (load latency 1).
module data_memory
  import dm_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  input  logic [1:0]  StoreType,
  input  logic [2:0]  LoadType,
  output logic [31:0] MemDataOut,
  output logic        AddrExc
);

  localparam int          IDX_W = $clog2(DM_WORDS);
  localparam logic [32:0] LIMIT = 33'(4 * DM_WORDS);

  logic [31:0]      r_mem [DM_WORDS];
  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  logic             w_st_mis;
  logic             w_ld_mis;
  logic             w_exc;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_do_write;
  logic             w_do_load;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_ext;

  assign w_idx     = Addr[IDX_W+1:2];
  assign w_oor     = {1'b0, Addr} >= LIMIT;
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    w_st_mis = 1'b0;
    w_be     = 4'b0000;
    w_wdata  = WData;
    case (store_type_e'(StoreType))
      ST_SW: begin
        w_st_mis = Addr[1:0] != 2'b00;
        w_be     = 4'b1111;
      end
      ST_SH: begin
        w_st_mis = Addr[0];
        w_be     = Addr[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{WData[15:0]}};
      end
      ST_SB: begin
        w_be    = 4'b0001 << Addr[1:0];
        w_wdata = {4{WData[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
  end

  always_comb begin
    case (load_type_e'(LoadType))
      LT_LH, LT_LHU: w_ld_mis = Addr[0];
      LT_LB, LT_LBU: w_ld_mis = 1'b0;
      default:       w_ld_mis = Addr[1:0] != 2'b00;
    endcase
  end

  // A simultaneous store takes precedence, so its checks decide the flag.
  always_comb begin
    w_exc = 1'b0;
    if (MemWrite)     w_exc = w_oor || w_st_mis;
    else if (MemRead) w_exc = w_oor || w_ld_mis;
  end

  assign w_do_write = MemWrite && !w_exc;
  assign w_do_load  = MemRead && !MemWrite && !w_exc;

  load_ext u_load_ext (
    .i_word      (w_rd_word),
    .i_lane      (Addr[1:0]),
    .i_load_type (LoadType),
    .o_data      (w_ext)
  );

  // Loads sample pre-edge contents; a store lands on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= '0;
      MemDataOut <= '0;
      AddrExc    <= 1'b0;
    end else begin
      if (w_do_write) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
      MemDataOut <= w_do_load ? w_ext : 32'h0;
      AddrExc    <= w_exc;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: driver pushes expected {AddrExc, MemDataOut}
// per sampled request or reset cycle; a monitor pops and compares one cycle later.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [1:0]  StoreType;
  logic [2:0]  LoadType;
  logic [31:0] MemDataOut;
  logic        AddrExc;

  logic [32:0] exp_q[$];
  logic        out_pending = 1'b0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, SR = 2'b11;
  localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011,
                         LBU = 3'b100, LRS = 3'b111;

  always #5 clk = ~clk;

  data_memory #(.DM_WORDS(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Addr       (Addr),
    .WData      (WData),
    .StoreType  (StoreType),
    .LoadType   (LoadType),
    .MemDataOut (MemDataOut),
    .AddrExc    (AddrExc)
  );

  // Marks cycles whose outputs must be checked (request or reset sampled).
  always @(posedge clk) out_pending <= !reset || MemRead || MemWrite;

  always @(negedge clk) begin
    if (out_pending) begin
      logic [32:0] exp_v;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got exc=%0b data=%08h, no expected entry", AddrExc, MemDataOut);
      end else begin
        exp_v = exp_q.pop_front();
        if ({AddrExc, MemDataOut} !== exp_v) begin
          errors++;
          $display("FAIL resp#%0d: got exc=%0b data=%08h, expected exc=%0b data=%08h",
                   checks, AddrExc, MemDataOut, exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  task automatic req(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] st, input logic [2:0] lt,
                     input logic e_exc, input logic [31:0] e_data);
    @(posedge clk);
    #1;
    reset = 1'b1; MemWrite = we; MemRead = re; Addr = a; WData = wd;
    StoreType = st; LoadType = lt;
    exp_q.push_back({e_exc, e_data});
  endtask

  task automatic st_op(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] st,
                       input logic e_exc);
    req(1'b1, 1'b0, a, wd, st, LW, e_exc, 32'h0);
  endtask

  task automatic ld_op(input logic [31:0] a, input logic [2:0] lt,
                       input logic e_exc, input logic [31:0] e_data);
    req(1'b0, 1'b1, a, 32'h0, SW, lt, e_exc, e_data);
  endtask

  task automatic rst_cycle(input logic we, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset = 1'b0; MemWrite = we; MemRead = 1'b0; Addr = a; WData = wd;
    StoreType = SW; LoadType = LW;
    exp_q.push_back(33'h0);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Addr = '0; WData = '0;
    StoreType = SW; LoadType = LW;
    rst_cycle(1'b0, 32'h0, 32'h0);
    rst_cycle(1'b0, 32'h0, 32'h0);

    // word store then back-to-back load
    st_op(32'h10, 32'hDEADBEEF, SW, 1'b0);
    ld_op(32'h10, LW, 1'b0, 32'hDEADBEEF);

    // byte store into top lane; upper WData bits must be ignored
    st_op(32'h10, 32'h0, SW, 1'b0);
    st_op(32'h13, 32'hAAAAAA80, SB, 1'b0);
    ld_op(32'h13, LB,  1'b0, 32'hFFFFFF80);
    ld_op(32'h13, LBU, 1'b0, 32'h00000080);
    ld_op(32'h10, LW,  1'b0, 32'h80000000);

    // upper half store keeps the low half
    st_op(32'h20, 32'h11223344, SW, 1'b0);
    st_op(32'h22, 32'h55558001, SH, 1'b0);
    ld_op(32'h22, LH,  1'b0, 32'hFFFF8001);
    ld_op(32'h22, LHU, 1'b0, 32'h00008001);
    ld_op(32'h20, LW,  1'b0, 32'h80013344);

    // misaligned and out-of-range accesses
    st_op(32'h4, 32'hCAFEF00D, SW, 1'b0);
    st_op(32'h6, 32'hFFFFFFFF, SW, 1'b1);
    ld_op(32'h5, LH, 1'b1, 32'h0);
    ld_op(32'h4, LW, 1'b0, 32'hCAFEF00D);
    st_op(32'h1000, 32'h5A5A5A5A, SW, 1'b1);
    ld_op(32'h1000, LW, 1'b1, 32'h0);
    ld_op(32'h0, LW, 1'b0, 32'h0);
    st_op(32'hFFC, 32'h0BADCAFE, SW, 1'b0);
    ld_op(32'hFFC, LW, 1'b0, 32'h0BADCAFE);
    ld_op(32'h32, LW, 1'b1, 32'h0);

    // reset aborts a coincident store and clears everything
    st_op(32'h40, 32'h77777777, SW, 1'b0);
    rst_cycle(1'b1, 32'h40, 32'h99999999);
    ld_op(32'h40, LW, 1'b0, 32'h0);
    ld_op(32'h10, LW, 1'b0, 32'h0);

    // write wins over a simultaneous read
    req(1'b1, 1'b1, 32'h30, 32'h12345678, SW, LW, 1'b0, 32'h0);
    ld_op(32'h30, LW,  1'b0, 32'h12345678);
    ld_op(32'h30, LB,  1'b0, 32'h00000078);
    ld_op(32'h31, LB,  1'b0, 32'h00000056);
    ld_op(32'h30, LH,  1'b0, 32'h00005678);
    ld_op(32'h30, LRS, 1'b0, 32'h12345678);
    st_op(32'h30, 32'hFFFFFFFF, SR, 1'b0);
    st_op(32'h31, 32'h000000F0, SB, 1'b0);
    ld_op(32'h30, LW,  1'b0, 32'h1234F078);
    ld_op(32'h32, LH,  1'b0, 32'h00001234);

    for (int i = 0; i < 4; i++) idle();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unconsumed entries, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
